mips_cpu_store_rmw: RTL and testbench

Parametrised sub-word store engine for the MIPS CPU datapath. Executes byte, halfword and full-width stores against a single-port data memory with wait-request. Without byte enables it performs a read-modify-write; with byte enables it issues one masked write. While busy it raises `stall` to freeze the PC and the register file, replacing the fixed three-stage SB/SH instruction rescheduling.

---
 rtl/store_rmw_pkg.sv | 32 +++
 rtl/mips_cpu_store_rmw_byte_lane_merge.sv | 19 +
 rtl/mips_cpu_store_rmw.sv | 212 +++++++++++++++++++++
 tb/tb_mips_cpu_store_rmw.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_rmw_pkg.sv
// Shared types, size codes and lane-mask helper for the sub-word store engine.
package store_rmw_pkg;

  // Store engine FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  // req_size encodings: log2 of the store size in bytes.
  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  // Widest data path the helper supports (1024-bit bus = 128 lanes).
  localparam int MAX_LANES = 128;
  localparam int MAX_OFS_W = 7;

  // Little-endian lane mask: (1<<size) contiguous lanes starting at lane ofs.
  // Callers cast the result down to their own lane count.
  function automatic logic [MAX_LANES-1:0] lane_mask(input logic [1:0]           size,
                                                     input logic [MAX_OFS_W-1:0] ofs);
    logic [3:0]           nbytes;
    logic [MAX_LANES-1:0] base;
    nbytes = 4'd1 << size;
    base   = (MAX_LANES'(1) << nbytes) - MAX_LANES'(1);
    return base << ofs;
  endfunction

endpackage

// File: rtl/mips_cpu_store_rmw_byte_lane_merge.sv
// Per-lane byte merge: selected lanes take the new byte, the rest keep the old byte.
module byte_lane_merge #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   old_i,
  input  logic [DATA_W-1:0]   new_i,
  input  logic [DATA_W/8-1:0] mask_i,
  output logic [DATA_W-1:0]   merged_o
);

  genvar gi;
  generate
    for (gi = 0; gi < DATA_W/8; gi++) begin : g_lane
      // One mux per byte lane.
      assign merged_o[gi*8 +: 8] = mask_i[gi] ? new_i[gi*8 +: 8] : old_i[gi*8 +: 8];
    end
  endgenerate

endmodule

// File: rtl/mips_cpu_store_rmw.sv
// Sub-word store engine for the MIPS datapath. Performs byte/half/word/dword
// stores against a single-port memory with wait-request. Sub-word stores use a
// read-modify-write unless STORE_RMW_BYTEENABLE_EN is defined, in which case
// every store is a single masked write. stall freezes the PC/register file
// while a store is in flight. All outputs are registered.
module mips_cpu_store_rmw
  import store_rmw_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clk_enable,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_size,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                stall,
  output logic                done,
  output logic                err,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_read,
  output logic                mem_write,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic [DATA_W-1:0]   mem_writedata,
  input  logic [DATA_W-1:0]   mem_readdata,
  input  logic                mem_waitrequest
);

  localparam int LANES = DATA_W / 8;
  localparam int OFS_W = $clog2(LANES);

`ifdef STORE_RMW_BYTEENABLE_EN
  localparam bit BE_MODE = 1'b1;
`else
  localparam bit BE_MODE = 1'b0;
`endif

  state_t              state_q, state_d;
  logic                req_ready_q, req_ready_d;
  logic                stall_q, stall_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
  logic [DATA_W-1:0]   mem_writedata_q, mem_writedata_d;
  logic [LANES-1:0]    mem_byteenable_q, mem_byteenable_d;
  // Latched, lane-aligned store data and its lane mask for the RMW write.
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [LANES-1:0]    mask_q, mask_d;

  // Request decode.
  logic [OFS_W-1:0]    req_ofs;
  logic [LANES-1:0]    req_mask;
  logic [DATA_W-1:0]   req_shifted;
  logic [2:0]          align_bits;
  logic                req_misaligned;
  logic                req_size_bad;
  logic                req_bad;
  logic                req_full;
  logic                req_direct;
  logic                req_accept;

  // Merge results: direct write (zero background) and RMW write (read background).
  logic [DATA_W-1:0]   merged_req;
  logic [DATA_W-1:0]   merged_rmw;

  assign req_ofs        = req_addr[OFS_W-1:0];
  assign req_mask       = LANES'(lane_mask(req_size, MAX_OFS_W'(req_ofs)));
  assign req_shifted    = req_wdata << {req_ofs, 3'b000};
  assign align_bits     = 3'((4'd1 << req_size) - 4'd1);
  assign req_misaligned = |(req_addr[2:0] & align_bits);
  assign req_size_bad   = int'(req_size) > OFS_W;
  assign req_bad        = req_misaligned || req_size_bad;
  assign req_full       = int'(req_size) == OFS_W;
  assign req_direct     = req_full || BE_MODE;
  assign req_accept     = req_valid && req_ready_q;

  // Unselected lanes of a direct write are zero; for a full-width store every
  // lane is selected so this is simply the request data.
  byte_lane_merge #(.DATA_W(DATA_W)) u_merge_req (
    .old_i    ('0),
    .new_i    (req_shifted),
    .mask_i   (req_mask),
    .merged_o (merged_req)
  );

  // RMW: new bytes over the word returned by the read.
  byte_lane_merge #(.DATA_W(DATA_W)) u_merge_rmw (
    .old_i    (mem_readdata),
    .new_i    (wdata_q),
    .mask_i   (mask_q),
    .merged_o (merged_rmw)
  );

  // State and registered outputs; clk_enable low freezes everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= ST_IDLE;
      req_ready_q      <= 1'b1;
      stall_q          <= 1'b0;
      done_q           <= 1'b0;
      err_q            <= 1'b0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_address_q    <= '0;
      mem_writedata_q  <= '0;
      mem_byteenable_q <= '0;
      wdata_q          <= '0;
      mask_q           <= '0;
    end else if (clk_enable) begin
      state_q          <= state_d;
      req_ready_q      <= req_ready_d;
      stall_q          <= stall_d;
      done_q           <= done_d;
      err_q            <= err_d;
      mem_read_q       <= mem_read_d;
      mem_write_q      <= mem_write_d;
      mem_address_q    <= mem_address_d;
      mem_writedata_q  <= mem_writedata_d;
      mem_byteenable_q <= mem_byteenable_d;
      wdata_q          <= wdata_d;
      mask_q           <= mask_d;
    end
  end

  // Next-state: direct stores skip READ; strobes advance only when accepted.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_accept && !req_bad) begin
          state_d = req_direct ? ST_WRITE : ST_READ;
        end
      end
      ST_READ: begin
        if (!mem_waitrequest) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (!mem_waitrequest) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; bus fields hold while a strobe waits.
  always_comb begin
    req_ready_d      = (state_d == ST_IDLE);
    stall_d          = (state_d != ST_IDLE);
    done_d           = 1'b0;
    err_d            = 1'b0;
    mem_read_d       = mem_read_q;
    mem_write_d      = mem_write_q;
    mem_address_d    = mem_address_q;
    mem_writedata_d  = mem_writedata_q;
    mem_byteenable_d = mem_byteenable_q;
    wdata_d          = wdata_q;
    mask_d           = mask_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_accept) begin
          if (req_bad) begin
            err_d = 1'b1;
          end else begin
            mem_address_d = {req_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
            wdata_d       = req_shifted;
            mask_d        = req_mask;
            if (req_direct) begin
              mem_write_d      = 1'b1;
              mem_writedata_d  = merged_req;
              mem_byteenable_d = BE_MODE ? req_mask : '1;
            end else begin
              mem_read_d = 1'b1;
            end
          end
        end
      end
      ST_READ: begin
        if (!mem_waitrequest) begin
          mem_read_d       = 1'b0;
          mem_write_d      = 1'b1;
          mem_writedata_d  = merged_rmw;
          mem_byteenable_d = '1;
        end
      end
      ST_WRITE: begin
        if (!mem_waitrequest) begin
          mem_write_d = 1'b0;
          done_d      = 1'b1;
        end
      end
      default: begin
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  assign req_ready      = req_ready_q;
  assign stall          = stall_q;
  assign done           = done_q;
  assign err            = err_q;
  assign mem_address    = mem_address_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign mem_byteenable = mem_byteenable_q;
  assign mem_writedata  = mem_writedata_q;

endmodule

// File: tb/tb_mips_cpu_store_rmw.sv
// Self-checking bench for mips_cpu_store_rmw. Default build: 32-bit RMW.
// With STORE_RMW_BYTEENABLE_EN defined the bench uses a 64-bit bus and
// expects single masked writes.
module tb_mips_cpu_store_rmw;
  import store_rmw_pkg::*;

`ifdef STORE_RMW_BYTEENABLE_EN
  localparam int DW = 64;
  localparam bit BE_MODE = 1'b1;
`else
  localparam int DW = 32;
  localparam bit BE_MODE = 1'b0;
`endif
  localparam int LANES = DW / 8;
  localparam int OFS_W = $clog2(LANES);
  localparam int NSTIM = 9;

  typedef struct {
    logic [31:0]      addr;
    logic [DW-1:0]    data;
    logic [LANES-1:0] be;
  } wr_t;

  typedef struct {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    int          rd_w;
    int          wr_w;
    int          fr;
  } stim_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             clk_enable;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_size;
  logic [31:0]      req_addr;
  logic [DW-1:0]    req_wdata;
  logic             stall;
  logic             done;
  logic             err;
  logic [31:0]      mem_address;
  logic             mem_read;
  logic             mem_write;
  logic [LANES-1:0] mem_byteenable;
  logic [DW-1:0]    mem_writedata;
  logic [DW-1:0]    mem_readdata = '0;
  logic             mem_waitrequest = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  wr_t           sb[$];
  logic [DW-1:0] mem_model [logic [31:0]];
  int            rd_cfg = 0;
  int            wr_cfg = 0;
  int            rd_left = 0;
  int            wr_left = 0;
  int            strobe_cnt = 0;
  logic          prev_rd = 1'b0;
  logic          prev_wr = 1'b0;
  logic          prev_pending = 1'b0;
  logic [31:0]      prev_addr = '0;
  logic [DW-1:0]    prev_wd = '0;
  logic [LANES-1:0] prev_be = '0;
  logic [31:0]      last_addr = '0;
  logic [DW-1:0]    last_data = '0;
  logic [LANES-1:0] last_be = '0;

  stim_t stim [NSTIM] = '{
    '{2'd0, 32'h0000_0103, 32'h0000_00AB, 0, 0, 0},
    '{2'd1, 32'h0000_0102, 32'h0000_BEEF, 2, 0, 0},
    '{2'd2, 32'h0000_0200, 32'hDEAD_BEEF, 0, 0, 0},
    '{2'd1, 32'h0000_0101, 32'h0000_1111, 0, 0, 0},
    '{2'd3, 32'h0000_0208, 32'h1357_9BDF, 0, 0, 0},
    '{2'd0, 32'h0000_0301, 32'h0000_005A, 0, 3, 0},
    '{2'd0, 32'h0000_0302, 32'h0000_00C3, 0, 0, 2},
    '{2'd1, 32'h0000_0306, 32'h0000_1234, 1, 1, 0},
    '{2'd0, 32'h0000_0105, 32'h0000_007E, 0, 0, 0}
  };

  mips_cpu_store_rmw #(.DATA_W(DW), .ADDR_W(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .clk_enable      (clk_enable),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_size        (req_size),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .stall           (stall),
    .done            (done),
    .err             (err),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byteenable  (mem_byteenable),
    .mem_writedata   (mem_writedata),
    .mem_readdata    (mem_readdata),
    .mem_waitrequest (mem_waitrequest)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_read(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : '0;
  endfunction

  // Reference behaviour of one store: alignment verdict, path, and the write it must produce.
  function automatic void model_store(input logic [1:0] size, input logic [31:0] addr,
                                      input logic [DW-1:0] data, output bit bad,
                                      output bit direct, output wr_t w);
    int            ofs;
    int            nb;
    bit            in_l;
    logic [DW-1:0] old;
    ofs    = int'(addr % LANES);
    nb     = 1 << size;
    bad    = ((addr % nb) != 0) || (int'(size) > OFS_W);
    direct = BE_MODE || (int'(size) == OFS_W);
    w.addr = addr - 32'(ofs);
    w.data = '0;
    w.be   = '0;
    old    = model_read(w.addr);
    for (int i = 0; i < LANES; i++) begin
      in_l    = (i >= ofs) && (i < ofs + nb);
      w.be[i] = BE_MODE ? in_l : 1'b1;
      if (in_l) w.data[8*i +: 8] = data[8*(i-ofs) +: 8];
      else if (!BE_MODE) w.data[8*i +: 8] = old[8*i +: 8];
    end
  endfunction

  // Memory responder: wait states, read data, write scoreboard, bus stability.
  always @(negedge clk) begin
    wr_t e;
    if (!reset) begin
      prev_pending    = 1'b0;
      prev_rd         = 1'b0;
      prev_wr         = 1'b0;
      mem_waitrequest = 1'b0;
    end else begin
      check_value("rd_wr_exclusive", 64'(mem_read & mem_write), 64'd0);
      if (prev_pending && (mem_read || mem_write)) begin
        check_value("addr_stable", 64'(mem_address), 64'(prev_addr));
        if (mem_write) begin
          check_value("wdata_stable", 64'(mem_writedata), 64'(prev_wd));
          check_value("be_stable", 64'(mem_byteenable), 64'(prev_be));
        end
      end
      if (mem_read) begin
        if (!prev_rd) rd_left = rd_cfg;
        if (rd_left > 0) begin
          mem_waitrequest = 1'b1;
          if (clk_enable) rd_left--;
        end else begin
          mem_waitrequest = 1'b0;
          mem_readdata    = model_read(mem_address);
        end
      end else if (mem_write) begin
        if (!prev_wr) wr_left = wr_cfg;
        if (wr_left > 0) begin
          mem_waitrequest = 1'b1;
          if (clk_enable) wr_left--;
        end else begin
          mem_waitrequest = 1'b0;
          if (clk_enable) begin
            if (sb.size() == 0) begin
              check_value("write_expected", 64'd0, 64'd1);
            end else begin
              e = sb.pop_front();
              check_value("wr_addr", 64'(mem_address), 64'(e.addr));
              check_value("wr_data", 64'(mem_writedata), 64'(e.data));
              check_value("wr_be", 64'(mem_byteenable), 64'(e.be));
            end
            if (!mem_model.exists(mem_address)) mem_model[mem_address] = '0;
            for (int i = 0; i < LANES; i++)
              if (mem_byteenable[i]) mem_model[mem_address][8*i +: 8] = mem_writedata[8*i +: 8];
            last_addr = mem_address;
            last_data = mem_writedata;
            last_be   = mem_byteenable;
          end
        end
      end else begin
        mem_waitrequest = 1'b0;
      end
      if (mem_read || mem_write) strobe_cnt++;
      prev_pending = (mem_read || mem_write) && (mem_waitrequest || !clk_enable);
      prev_rd      = mem_read;
      prev_wr      = mem_write;
      prev_addr    = mem_address;
      prev_wd      = mem_writedata;
      prev_be      = mem_byteenable;
    end
  end

  // One store: drive, wait (bounded) for done/err, check timing and flags.
  task automatic run_store(input stim_t s);
    bit   bad;
    bit   direct;
    wr_t  w;
    int   exp_lat;
    int   cyc;
    int   sc0;
    bit   got;
    logic st1;
    logic rdy;
    logic dn;
    logic er;
    model_store(s.size, s.addr, DW'(s.data), bad, direct, w);
    exp_lat = bad ? 1 : ((direct ? 2 : 3 + s.rd_w) + s.wr_w + s.fr);
    rd_cfg  = s.rd_w;
    wr_cfg  = s.wr_w;
    @(posedge clk); #1;
    if (!bad) sb.push_back(w);
    sc0       = strobe_cnt;
    req_valid = 1'b1;
    req_size  = s.size;
    req_addr  = s.addr;
    req_wdata = DW'(s.data);
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 0;
    got = 1'b0;
    st1 = 1'b0;
    fork
      begin
        if (s.fr > 0) begin
          clk_enable = 1'b0;
          repeat (s.fr) @(posedge clk);
          #1 clk_enable = 1'b1;
        end
      end
      begin
        while (cyc < 60 && !got) begin
          @(negedge clk);
          cyc++;
          if (cyc == 1) st1 = stall;
          if (done || err) got = 1'b1;
        end
      end
    join
    rdy = req_ready;
    dn  = done;
    er  = err;
    check_value("latency", 64'(cyc), 64'(exp_lat));
    check_value("err_flag", 64'(er), 64'(bad));
    check_value("done_flag", 64'(dn), 64'(!bad));
    check_value("stall_cycle1", 64'(st1), 64'(!bad));
    check_value("ready_at_end", 64'(rdy), 64'd1);
    if (bad) check_value("err_no_strobes", 64'(strobe_cnt - sc0), 64'd0);
    @(negedge clk);
    check_value("pulse_one_cycle", 64'({done, err}), 64'd0);
    check_value("stall_idle", 64'(stall), 64'd0);
    $display("[TB] store size=%0d addr=0x%08h data=0x%08h rd_w=%0d wr_w=%0d fr=%0d -> lat=%0d err=%0d",
             s.size, s.addr, s.data, s.rd_w, s.wr_w, s.fr, cyc, er);
  endtask

  initial begin
    bit    bad;
    bit    direct;
    bit    seen;
    wr_t   w;
    stim_t post;
    reset      = 1'b0;
    clk_enable = 1'b1;
    req_valid  = 1'b0;
    req_size   = '0;
    req_addr   = '0;
    req_wdata  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_value("rst_req_ready", 64'(req_ready), 64'd1);
    check_value("rst_stall", 64'(stall), 64'd0);
    check_value("rst_done", 64'(done), 64'd0);
    check_value("rst_err", 64'(err), 64'd0);
    check_value("rst_mem_read", 64'(mem_read), 64'd0);
    check_value("rst_mem_write", 64'(mem_write), 64'd0);
    check_value("rst_mem_address", 64'(mem_address), 64'd0);
    check_value("rst_mem_writedata", 64'(mem_writedata), 64'd0);
    check_value("rst_mem_byteenable", 64'(mem_byteenable), 64'd0);
    reset = 1'b1;

    for (int i = 0; i < NSTIM; i++) begin
      if (i < 2) mem_model[32'h100] = DW'(32'h1122_3344);
      run_store(stim[i]);
`ifndef STORE_RMW_BYTEENABLE_EN
      if (i == 0) begin
        check_value("sb103_word", 64'(last_data), 64'h0000_0000_AB22_3344);
        check_value("sb103_addr", 64'(last_addr), 64'h100);
      end
      if (i == 1) check_value("sh102_word", 64'(last_data), 64'h0000_0000_BEEF_3344);
      if (i == 2) begin
        check_value("sw200_word", 64'(last_data), 64'h0000_0000_DEAD_BEEF);
        check_value("sw200_be", 64'(last_be), 64'hF);
      end
`else
      if (i == 8) begin
        check_value("be_sb105_data", 64'(last_data), 64'h0000_7E00_0000_0000);
        check_value("be_sb105_be", 64'(last_be), 64'h20);
        check_value("be_sb105_addr", 64'(last_addr), 64'h100);
      end
`endif
    end

    // Reset while a write is stalled by wait-request.
    model_store(2'd2, 32'h0000_0400, DW'(32'hCAFE_F00D), bad, direct, w);
    wr_cfg = 20;
    rd_cfg = 0;
    @(posedge clk); #1;
    sb.push_back(w);
    req_valid = 1'b1;
    req_size  = 2'd2;
    req_addr  = 32'h0000_0400;
    req_wdata = DW'(32'hCAFE_F00D);
    @(posedge clk); #1;
    req_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (mem_write) seen = 1'b1;
    end
    check_value("rst_test_write_seen", 64'(seen), 64'd1);
    #2 reset = 1'b0;
    #1;
    check_value("async_rst_mem_write", 64'(mem_write), 64'd0);
    check_value("async_rst_mem_read", 64'(mem_read), 64'd0);
    check_value("async_rst_stall", 64'(stall), 64'd0);
    check_value("async_rst_ready", 64'(req_ready), 64'd1);
    sb.delete();
    wr_cfg = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check_value("rst_no_done", 64'(seen), 64'd0);
    $display("[TB] reset during stalled write at 0x00000400 -> store dropped");

    post = '{2'd2, 32'h0000_0500, 32'h0BAD_F00D, 0, 0, 0};
    run_store(post);

    check_value("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
